mac_operand_fifo: RTL

// - Operand buffer directly upstream of the signed 8x8 MAC stage.
// - Accepts (a,b) operand pairs from a producer over a valid/ready handshake and

---
 rtl/mac_operand_fifo_if.sv | 27 ++
 rtl/mac_operand_fifo.sv | 92 +++++++++
 2 files changed

// File: rtl/mac_operand_fifo_if.sv
// Producer/consumer bundle for mac_operand_fifo: valid/ready push side, paced MAC stream side.
// The slave modport is the FIFO's own view; master is the view of whoever drives it.
interface mac_operand_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic [WIDTH-1:0]         s_a;
  logic [WIDTH-1:0]         s_b;
  logic                     pop_en;
  logic                     m_valid;
  logic [WIDTH-1:0]         m_a;
  logic [WIDTH-1:0]         m_b;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output s_valid, s_a, s_b, pop_en,
    input  s_ready, m_valid, m_a, m_b, count, overflow
  );

  modport slave (
    input  s_valid, s_a, s_b, pop_en,
    output s_ready, m_valid, m_a, m_b, count, overflow
  );
endinterface

// File: rtl/mac_operand_fifo.sv
// Circular operand FIFO feeding the signed 8x8 MAC as a registered valid/a/b stream paced by pop_en.
// Optional sticky push-while-full flag is built only when MAC_OPERAND_FIFO_OVERFLOW_EN is defined.
module mac_operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  mac_operand_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               m_valid_q;
  logic [WIDTH-1:0]   m_a_q;
  logic [WIDTH-1:0]   m_b_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.s_valid & ~full;
  assign pop   = bus.pop_en & ~empty;

  assign bus.s_ready = ~full;
  assign bus.count   = count_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_a     = m_a_q;
  assign bus.m_b     = m_b_q;

  // Storage deliberately has no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.s_a, bus.s_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Operands hold their last value between pops so the MAC sees stable inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      m_valid_q <= pop;
      if (pop) begin
        m_a_q <= mem[rd_ptr][2*WIDTH-1:WIDTH];
        m_b_q <= mem[rd_ptr][WIDTH-1:0];
      end
    end
  end

`ifdef MAC_OPERAND_FIFO_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    overflow_q <= 1'b0;
    else if (bus.s_valid && full) overflow_q <= 1'b1;
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule
